// File: rtl/occ_meter.sv
// occ_meter: counts hits over a window of WINDOW enabled cycles and reports
// the saturated hit count together with the switch pattern of the nearest
// occupancy class.
module occ_meter #(
  parameter int WINDOW   = 128,
  parameter int OCC_SIZE = 7,
  parameter int LVL_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic                hit,
  output logic [OCC_SIZE-1:0] occ_out,
  output logic [LVL_SIZE-1:0] lvl_out,
  output logic                occ_valid,
  output logic                sat
);

  localparam int WIN_W   = $clog2(WINDOW);
  localparam int HIT_W   = $clog2(WINDOW + 1);
  localparam int OCC_MAX = (1 << OCC_SIZE) - 1;

  // Maps a saturated occupancy value onto the selector's switch pattern.
  // Class 32 uses bit 1 only; bit 2 is never driven by the selector.
  function automatic logic [LVL_SIZE-1:0] decode_lvl(input logic [OCC_SIZE-1:0] occ);
    logic [31:0] v;
    v = 32'(occ);
    if (v < 32'd16) begin
      decode_lvl = LVL_SIZE'(4'b0001);
    end else if (v < 32'd48) begin
      decode_lvl = LVL_SIZE'(4'b0010);
    end else if (v < 32'd93) begin
      decode_lvl = LVL_SIZE'(4'b1000);
    end else begin
      decode_lvl = LVL_SIZE'(4'b0000);
    end
  endfunction

  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [HIT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [OCC_SIZE-1:0] occ_q, occ_d;
  logic [LVL_SIZE-1:0] lvl_q, lvl_d;
  logic                valid_q, valid_d;
  logic                sat_q, sat_d;

  logic                end_win_s;
  logic [HIT_W-1:0]    total_s;
  logic                over_s;
  logic [OCC_SIZE-1:0] occ_sat_s;

  // Window-closing arithmetic: the hit of the final cycle belongs to the window.
  always_comb begin
    end_win_s = en && (win_cnt_q == WIN_W'(WINDOW - 1));
    total_s   = hit_cnt_q + HIT_W'(hit);
    over_s    = (32'(total_s) > 32'(OCC_MAX));
    occ_sat_s = over_s ? OCC_SIZE'(OCC_MAX) : OCC_SIZE'(total_s);
  end

  // Next-state: clear beats end of window, which beats normal counting.
  always_comb begin
    win_cnt_d = win_cnt_q;
    hit_cnt_d = hit_cnt_q;
    occ_d     = occ_q;
    lvl_d     = lvl_q;
    sat_d     = sat_q;
    valid_d   = 1'b0;
    if (clear) begin
      win_cnt_d = '0;
      hit_cnt_d = '0;
    end else if (en) begin
      if (end_win_s) begin
        occ_d     = occ_sat_s;
        lvl_d     = decode_lvl(occ_sat_s);
        sat_d     = over_s;
        valid_d   = 1'b1;
        win_cnt_d = '0;
        hit_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        hit_cnt_d = total_s;
      end
    end else begin
      win_cnt_d = win_cnt_q;
      hit_cnt_d = hit_cnt_q;
    end
  end

  // State and report registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_cnt_q <= '0;
      hit_cnt_q <= '0;
      occ_q     <= '0;
      lvl_q     <= LVL_SIZE'(4'b0001);
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      occ_q     <= occ_d;
      lvl_q     <= lvl_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
    end
  end

  assign occ_out   = occ_q;
  assign lvl_out   = lvl_q;
  assign occ_valid = valid_q;
  assign sat       = sat_q;

endmodule
